// File: rtl/reg_dump_pkg.sv
// Shared register-file constants and the dump reader state encoding.
package reg_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Control, register-file read port and output stream of the register dump reader.
interface reg_dump_reader_if
  import reg_dump_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) ();

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, rd_data, out_ready,
    output rd_addr, out_valid, out_addr, out_data, busy, done
  );

  modport slave (
    output start, abort, rd_data, out_ready,
    input  rd_addr, out_valid, out_addr, out_data, busy, done
  );

endinterface

// File: rtl/reg_dump_reader.sv
// Walks register addresses FIRST_REG..LAST_REG through one read port and streams
// each (address, data) pair over a valid/ready handshake.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int DATA_W    = REG_DATA_W,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic               clk,
  input  logic               rst,
  reg_dump_reader_if.master  bus
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

  dump_state_e       state_r;
  dump_state_e       state_s;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] idx_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [ADDR_W-1:0] out_addr_r;
  logic [DATA_W-1:0] out_data_r;
  logic              load_s;

  // Next-state, index update and read-port address; abort outranks everything.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    rd_addr_s = FIRST_IDX;
    load_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else if (bus.start) begin
          idx_s   = FIRST_IDX;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        rd_addr_s = idx_r;
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else begin
          load_s  = 1'b1;
          state_s = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else if (bus.out_ready) begin
          if (idx_r == LAST_IDX) begin
            state_s = ST_DONE;
          end else begin
            idx_s   = idx_r + IDX_ONE;
            state_s = ST_FETCH;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, index and the captured output word; data is sampled once, at FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= FIRST_IDX;
      out_addr_r <= {ADDR_W{1'b0}};
      out_data_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if (load_s) begin
        out_addr_r <= idx_r;
        out_data_r <= bus.rd_data;
      end else begin
        out_addr_r <= out_addr_r;
        out_data_r <= out_data_r;
      end
    end
  end

  assign bus.rd_addr   = rd_addr_s;
  assign bus.out_valid = (state_r == ST_SEND);
  assign bus.out_addr  = out_addr_r;
  assign bus.out_data  = out_data_r;
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.done      = (state_r == ST_DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench: scenario table with random backpressure against a queue model,
// plus hand-written reset and narrow-range sequences.
module tb_reg_dump_reader;
  import reg_dump_pkg::*;

  logic clk;
  logic rst;
  logic [31:0] regs [32];
  int n_tests;
  int n_fail;

  reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) a ();
  reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) b ();

  reg_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31)) dut_a (
    .clk(clk), .rst(rst), .bus(a)
  );
  reg_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(28), .LAST_REG(31)) dut_b (
    .clk(clk), .rst(rst), .bus(b)
  );

  // Register file model: register 0 is hardwired to zero.
  assign a.rd_data = (a.rd_addr == 5'd0) ? 32'd0 : regs[a.rd_addr];
  assign b.rd_data = (b.rd_addr == 5'd0) ? 32'd0 : regs[b.rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ready_pct;
    int abort_word;
    int glitch_at;
    int exp_words;
    int exp_dones;
  } scen_t;

  scen_t scens [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int i);
    return (i == 0) ? 32'd0 : regs[i];
  endfunction

  task automatic run_dump(input scen_t s);
    logic [4:0]  exp_a [$];
    logic [31:0] exp_d [$];
    int j, stalls, dones, words, abort_j;
    bit hold, fin;
    logic [4:0]  ha;
    logic [31:0] hd;
    for (int i = 0; i < 32; i++) begin
      exp_a.push_back(5'(i));
      exp_d.push_back(model_read(i));
    end
    @(negedge clk);
    a.start = 1'b1;
    a.out_ready = 1'b0;
    a.abort = 1'b0;
    @(posedge clk);
    j = 0; stalls = 0; dones = 0; words = 0; abort_j = -1;
    hold = 1'b0; fin = 1'b0; ha = 5'd0; hd = 32'd0;
    while (!fin) begin
      @(negedge clk);
      a.start = 1'b0;
      a.abort = 1'b0;
      a.out_ready = 1'b0;
      if (hold) begin
        check("stall_valid", 32'(a.out_valid), 32'd1);
        check("stall_addr", 32'(a.out_addr), 32'(ha));
        check("stall_data", a.out_data, hd);
      end
      hold = 1'b0;
      if (a.done) begin
        dones++;
        if (s.abort_word < 0) check("done_cycle", 32'(j), 32'(64 + stalls));
      end
      if (!a.busy) begin
        fin = 1'b1;
        if (abort_j >= 0) check("abort_idle_cycle", 32'(j), 32'(abort_j + 1));
        else check("busy_low_cycle", 32'(j), 32'(65 + stalls));
      end else if (j > 400) begin
        fin = 1'b1;
        check("dump_timeout", 32'(j), 32'd0);
      end else begin
        if (j == s.glitch_at) a.start = 1'b1;
        if (a.out_valid) begin
          if (int'(a.out_addr) == s.abort_word) begin
            a.abort = 1'b1;
            a.out_ready = 1'b1;
            abort_j = j;
          end else if ($urandom_range(99) < s.ready_pct) begin
            a.out_ready = 1'b1;
            words++;
            if (exp_a.size() == 0) begin
              check("extra_word", 32'(a.out_addr), 32'hFFFF_FFFF);
            end else begin
              check("word_addr", 32'(a.out_addr), 32'(exp_a.pop_front()));
              check("word_data", a.out_data, exp_d.pop_front());
            end
          end else begin
            stalls++;
            hold = 1'b1;
            ha = a.out_addr;
            hd = a.out_data;
          end
        end
        @(posedge clk);
        j++;
      end
    end
    check("words_accepted", 32'(words), 32'(s.exp_words));
    check("done_pulses", 32'(dones), 32'(s.exp_dones));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(a.out_valid), 32'd0);
    check({tag, "_busy"}, 32'(a.busy), 32'd0);
    check({tag, "_done"}, 32'(a.done), 32'd0);
    check({tag, "_addr"}, 32'(a.out_addr), 32'd0);
    check({tag, "_data"}, a.out_data, 32'd0);
    check({tag, "_rd_addr"}, 32'(a.rd_addr), 32'd0);
    check({tag, "_b_rd_addr"}, 32'(b.rd_addr), 32'd28);
    check({tag, "_b_busy"}, 32'(b.busy), 32'd0);
  endtask

  initial begin
    int j, w, dones;
    bit seen;
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    a.start = 1'b0; a.abort = 1'b0; a.out_ready = 1'b0;
    b.start = 1'b0; b.abort = 1'b0; b.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 | 32'(i);

    scens[0] = '{100, -1, -1, 32, 1};
    scens[1] = '{50,  -1, -1, 32, 1};
    scens[2] = '{100, 10, -1, 10, 0};
    scens[3] = '{100, -1,  7, 32, 1};
    scens[4] = '{50,  -1, 20, 32, 1};
    scens[5] = '{40,   5, -1,  5, 0};

    #12;
    check_reset_values("reset_held");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("after_reset");

    for (int k = 0; k < 6; k++) begin
      if (k > 0) for (int i = 0; i < 32; i++) regs[i] = $urandom;
      run_dump(scens[k]);
    end

    // Asynchronous reset while word 5 is on the output.
    @(negedge clk);
    a.start = 1'b1;
    a.out_ready = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      a.start = 1'b0;
      if (a.out_valid && a.out_addr == 5'd5) seen = 1'b1;
    end
    check("reset_word5_reached", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_values("mid_dump_reset");
    a.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("post_mid_reset");

    // Narrow range 28..31 with the consumer always ready.
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    @(negedge clk);
    b.start = 1'b1;
    b.out_ready = 1'b1;
    @(posedge clk);
    j = 0; w = 0; dones = 0;
    seen = 1'b0;
    while (!seen) begin
      @(negedge clk);
      b.start = 1'b0;
      if (b.out_valid) begin
        check("narrow_addr", 32'(b.out_addr), 32'(28 + w));
        check("narrow_data", b.out_data, model_read(28 + w));
        w++;
      end
      if (b.done) begin
        dones++;
        check("narrow_done_cycle", 32'(j), 32'd8);
      end
      if (!b.busy) begin
        seen = 1'b1;
        check("narrow_busy_low", 32'(j), 32'd9);
      end else if (j > 40) begin
        seen = 1'b1;
        check("narrow_timeout", 32'(j), 32'd0);
      end else begin
        @(posedge clk);
        j++;
      end
    end
    b.out_ready = 1'b0;
    check("narrow_words", 32'(w), 32'd4);
    check("narrow_dones", 32'(dones), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Sequential reader for the 32×32 CPU register file. It walks a range of register addresses through one read port and streams each `(address, data)` pair out over a valid/ready handshake. It sits between the register file's spare read port and the debug display/UART path of the bomb-sweep SoC. It does not write the register file.

## Interface
Parameters:
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: register data width.
- `FIRST_REG`, 0: first address dumped.
- `LAST_REG`, 31: last address dumped; requires `FIRST_REG <= LAST_REG < 2**ADDR_W`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a dump; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE without `done`.
- `rd_addr`  out  ADDR_W  address to the register-file read port.
- `rd_data`  in  DATA_W  combinational read data for `rd_addr`.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_addr`  out  ADDR_W  register index of the current word.
- `out_data`  out  DATA_W  register contents of the current word.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, FETCH, SEND, DONE. Index counter `idx` is ADDR_W bits wide.
- IDLE:
  - `rd_addr = FIRST_REG`.
  - If `start`, load `idx <= FIRST_REG` and go to FETCH.
- FETCH:
  - `rd_addr = idx`.
  - Register `out_data <= rd_data` and `out_addr <= idx`, then go to SEND.
- SEND:
  - `out_valid = 1`; `out_addr` and `out_data` hold stable until accepted.
  - On `out_valid && out_ready`:
    - If `idx == LAST_REG`, go to DONE.
    - Otherwise `idx <= idx + 1` and go to FETCH.
- DONE: `done = 1` for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored. A new dump needs `start` again after return to IDLE.
- `abort`:
  - Highest priority in FETCH, SEND and DONE; next state is IDLE.
  - No `done` pulse. A word pending in SEND is dropped, even if `out_ready` is high in the same cycle.
  - In IDLE, `abort` has priority over `start`.
- `idx` never wraps: it stops at `LAST_REG`. With `LAST_REG = 31` and `ADDR_W = 5`, no overflow occurs.
- Register contents are sampled at FETCH time. Writes to a register after its FETCH are not reflected in the dump.

## Timing
- Reset values: state IDLE, `idx = FIRST_REG`, `out_valid = 0`, `out_addr = 0`, `out_data = 0`, `busy = 0`, `done = 0`, `rd_addr = FIRST_REG`.
- Reset asserted mid-dump clears all state immediately (asynchronously). No `done` is produced.
- Edge numbering: E0 is the edge that samples `start`.
  - FETCH of word k runs in the cycle after E(2k).
  - Word k is valid in the cycle after E(2k+1).
  - With `out_ready` held high, word k is accepted at E(2k+2).
- Throughput: one word per 2 cycles at best. Each extra cycle of `out_ready = 0` adds one cycle.
- Full default dump with `out_ready` held high:
  - 32 words accepted at E2 through E64.
  - `done` high in the cycle after E64.
  - `busy` low after E65.
- `out_valid`, `out_addr`, `out_data` and `done` are registered or state-decoded. There is no combinational path from `out_ready` to any output.

## Structure
- Shared package `reg_dump_pkg` holds:
  - the state enum (IDLE, FETCH, SEND, DONE);
  - constants `REG_ADDR_W = 5` and `REG_DATA_W = 32`, shared with the register file and its other clients.
- Single module, no sub-modules; the index counter is inline.
- Test bench pairs this block with the existing register file, connecting `rd_addr`/`rd_data` to one read port.

## Test plan
- Preload register i with `0xA5000000 | i`, pulse `start`, hold `out_ready = 1`:
  - 32 words are received with `out_addr` 0..31 and `out_data` `0xA5000000`..`0xA500001F`; register 0 reads 0.
  - `done` is high for one cycle at E64+1; `busy` falls after E65.
- Random `out_ready` backpressure (about 50%):
  - `out_addr` and `out_data` hold stable while `out_valid && !out_ready`.
  - No word is lost or duplicated; total cycles = 65 + stall cycles.
- `abort` in SEND of word 10 with `out_ready = 1`:
  - Word 10 is not counted as accepted and there is no `done` pulse.
  - IDLE on the next cycle; a following `start` restarts from address 0.
- `start` pulsed during a dump:
  - Ignored; exactly 32 words and a single `done`.
- `rst` asserted mid-dump at word 5:
  - `out_valid`, `busy` and `done` are 0 immediately, before the next clock edge, and all outputs are at reset values.
- Parameters `FIRST_REG = 28`, `LAST_REG = 31`:
  - 4 words with addresses 28..31; `done` at E8+1.
